// File: rtl/pause_scheduler_if.sv
// Pause-control bundle between the FIFO watermark side (master) and the pause scheduler (slave).
interface pause_scheduler_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0] above_high;
  logic [NUM_PORTS-1:0] below_low;
  logic [NUM_PORTS-1:0] port_mask;
  logic                 pause_req;
  logic [15:0]          pause_val;
  logic [NUM_PORTS-1:0] port_paused;
  logic                 pause_active;

  modport master (
    output above_high, below_low, port_mask,
    input  pause_req, pause_val, port_paused, pause_active
  );

  modport slave (
    input  above_high, below_low, port_mask,
    output pause_req, pause_val, port_paused, pause_active
  );
endinterface

// File: rtl/pause_scheduler.sv
// Shares one MAC 802.3x pause port among NUM_PORTS FIFOs: watermark hysteresis -> XOFF/XON pulses,
// 2-cycle input-to-pulse latency, no backpressure; define PAUSE_REFRESH_EN for periodic XOFF re-send.
module pause_scheduler #(
  parameter int          NUM_PORTS      = 4,
  parameter logic [15:0] PAUSE_QUANTA   = 16'hFFFF,
  parameter int          MIN_GAP        = 16,
  parameter int unsigned REFRESH_CYCLES = 32768
) (
  input  logic              clk,
  input  logic              reset,
  pause_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, PAUSED} state_t;

  localparam logic [15:0] GAP_LIMIT = 16'(MIN_GAP);

  state_t               state;
  state_t               state_nxt;
  logic [NUM_PORTS-1:0] paused_q;
  logic [NUM_PORTS-1:0] paused_nxt;
  logic [15:0]          gap_cnt;
  logic                 gap_ok;
  logic                 any_cong;
  logic                 refresh_due;
  logic                 fire;
  logic [15:0]          val_nxt;
  logic                 pause_req_q;
  logic [15:0]          pause_val_q;

  // The input relevant to the current state wins when both watermarks are asserted.
  assign paused_nxt = (paused_q & ~bus.below_low) | (~paused_q & bus.above_high);
  assign any_cong   = |(paused_q & bus.port_mask);
  // The !pause_req_q term keeps pulses apart even when MIN_GAP is 1.
  assign gap_ok     = (gap_cnt >= GAP_LIMIT) && !pause_req_q;

`ifdef PAUSE_REFRESH_EN
  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);

  logic [31:0] refresh_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
    end else if (fire) begin
      refresh_cnt <= '0;
    end else if (state == PAUSED && refresh_cnt != '1) begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  assign refresh_due = (refresh_cnt >= REFRESH_LAST);
`else
  logic unused_cfg;
  assign unused_cfg  = ^REFRESH_CYCLES;
  assign refresh_due = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    val_nxt   = pause_val_q;
    case (state)
      IDLE: begin
        if (any_cong && gap_ok) begin
          fire      = 1'b1;
          val_nxt   = PAUSE_QUANTA;
          state_nxt = PAUSED;
        end
      end
      PAUSED: begin
        if (!any_cong) begin
          if (gap_ok) begin
            fire      = 1'b1;
            val_nxt   = 16'h0000;
            state_nxt = IDLE;
          end
        end else if (refresh_due && gap_ok) begin
          fire    = 1'b1;
          val_nxt = PAUSE_QUANTA;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paused_q    <= '0;
      gap_cnt     <= GAP_LIMIT;
      pause_req_q <= 1'b0;
      pause_val_q <= 16'h0000;
    end else begin
      paused_q    <= paused_nxt;
      pause_req_q <= fire;
      pause_val_q <= val_nxt;
      if (fire) begin
        gap_cnt <= 16'd1;
      end else if (gap_cnt < GAP_LIMIT) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

  assign bus.pause_req    = pause_req_q;
  assign bus.pause_val    = pause_val_q;
  assign bus.port_paused  = paused_q;
  assign bus.pause_active = (state == PAUSED);

endmodule

// File: tb/tb_pause_scheduler.sv
// Directed bench for pause_scheduler: expected pulses (cycle, value) are queued by the stimulus and
// popped by an independent monitor whenever pause_req is seen.
module tb_pause_scheduler;
  localparam int NP      = 4;
  localparam int GAP     = 16;
  localparam int REFRESH = 64;

  typedef struct {
    int          t;
    logic [15:0] v;
  } pulse_t;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  int     cyc   = 0;
  int     checks = 0;
  int     errors = 0;
  pulse_t exp_q[$];

  pause_scheduler_if #(.NUM_PORTS(NP)) itf ();

  pause_scheduler #(
    .NUM_PORTS     (NP),
    .PAUSE_QUANTA  (16'hFFFF),
    .MIN_GAP       (GAP),
    .REFRESH_CYCLES(REFRESH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (itf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_pulse(input int t, input logic [15:0] v);
    pulse_t p;
    p.t = t;
    p.v = v;
    exp_q.push_back(p);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every observed pulse must match the head of the expectation queue.
  logic   prev_req = 1'b0;
  pulse_t e;
  always @(negedge clk) begin
    if (itf.pause_req === 1'b1) begin
      chk("back_to_back", 32'(prev_req), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse at cycle %0d: got val %0h, want no pulse", cyc, itf.pause_val);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.t));
        chk("pulse_val", 32'(itf.pause_val), 32'(e.v));
      end
    end
    prev_req = itf.pause_req;
  end

  int t0;
  int last;
  int xon;

  initial begin
    itf.above_high = '0;
    itf.below_low  = '0;
    itf.port_mask  = 4'hF;
    reset          = 1'b1;
    step(3);
    chk("rst_req", 32'(itf.pause_req), 32'd0);
    chk("rst_val", 32'(itf.pause_val), 32'd0);
    chk("rst_paused", 32'(itf.port_paused), 32'd0);
    chk("rst_active", 32'(itf.pause_active), 32'd0);
    reset = 1'b0;
    step(2);

    // Single port XOFF then deferred XON.
    itf.above_high = 4'b0001;
    t0 = cyc + 2;
    expect_pulse(t0, 16'hFFFF);
    step(1);
    itf.above_high = '0;
    chk("t1_paused", 32'(itf.port_paused), 32'h1);
    step(1);
    chk("t1_active", 32'(itf.pause_active), 32'd1);
    step(1);
    itf.below_low = 4'b0001;
    expect_pulse(t0 + GAP, 16'h0000);
    step(1);
    itf.below_low = '0;
    chk("t1_cleared", 32'(itf.port_paused), 32'h0);
    step(t0 + GAP - 1 - cyc);
    chk("t1_still_active", 32'(itf.pause_active), 32'd1);
    step(1);
    chk("t1_idle", 32'(itf.pause_active), 32'd0);

    // Two congested ports: XON only after the last one drains.
    step(20);
    itf.above_high = 4'b0101;
    expect_pulse(cyc + 2, 16'hFFFF);
    step(1);
    itf.above_high = '0;
    chk("t2_paused", 32'(itf.port_paused), 32'h5);
    step(4);
    itf.below_low = 4'b0001;
    step(1);
    itf.below_low = '0;
    chk("t2_one_left", 32'(itf.port_paused), 32'h4);
    step(25);
    chk("t2_held", 32'(itf.pause_active), 32'd1);
    itf.below_low = 4'b0100;
    expect_pulse(cyc + 2, 16'h0000);
    step(1);
    itf.below_low = '0;
    step(2);
    chk("t2_idle", 32'(itf.pause_active), 32'd0);

    // Masked congestion: tracked but silent until unmasked; masking it again sends XON.
    step(20);
    itf.port_mask  = 4'b1101;
    itf.above_high = 4'b0010;
    step(1);
    itf.above_high = '0;
    chk("t3_paused", 32'(itf.port_paused), 32'h2);
    step(4);
    chk("t3_masked_idle", 32'(itf.pause_active), 32'd0);
    itf.port_mask = 4'hF;
    expect_pulse(cyc + 1, 16'hFFFF);
    step(20);
    itf.port_mask = 4'b1101;
    expect_pulse(cyc + 1, 16'h0000);
    step(2);
    itf.below_low = 4'b0010;
    step(1);
    itf.below_low = '0;
    itf.port_mask = 4'hF;
    chk("t3_cleared", 32'(itf.port_paused), 32'h0);

    // Long congestion: refresh XOFFs only when the feature is built in.
    step(20);
    itf.above_high = 4'b0001;
    t0 = cyc + 2;
    expect_pulse(t0, 16'hFFFF);
`ifdef PAUSE_REFRESH_EN
    expect_pulse(t0 + REFRESH, 16'hFFFF);
    expect_pulse(t0 + 2 * REFRESH, 16'hFFFF);
    expect_pulse(t0 + 3 * REFRESH, 16'hFFFF);
    last = t0 + 3 * REFRESH;
`else
    last = t0;
`endif
    step(1);
    itf.above_high = '0;
    step(t0 + 200 - cyc);
    chk("t4_val_held", 32'(itf.pause_val), 32'hFFFF);
    itf.below_low = 4'b0001;
    xon = (cyc + 2 > last + GAP) ? cyc + 2 : last + GAP;
    expect_pulse(xon, 16'h0000);
    step(1);
    itf.below_low = '0;
    step(xon - cyc + 1);
    chk("t4_idle", 32'(itf.pause_active), 32'd0);

    // Congestion clears and returns inside the gap: no pulse. Then reset mid-pause.
    step(20);
    itf.above_high = 4'b0001;
    expect_pulse(cyc + 2, 16'hFFFF);
    step(1);
    itf.above_high = '0;
    step(2);
    itf.below_low = 4'b0001;
    step(1);
    itf.below_low = '0;
    step(2);
    itf.above_high = 4'b0001;
    step(1);
    itf.above_high = '0;
    step(20);
    chk("t5_still_paused", 32'(itf.pause_active), 32'd1);
    reset = 1'b1;
    step(1);
    chk("t5_rst_req", 32'(itf.pause_req), 32'd0);
    chk("t5_rst_val", 32'(itf.pause_val), 32'd0);
    chk("t5_rst_paused", 32'(itf.port_paused), 32'd0);
    chk("t5_rst_active", 32'(itf.pause_active), 32'd0);
    reset = 1'b0;
    step(3);
    chk("t5_post_rst", 32'(itf.pause_active), 32'd0);

    // Both watermarks high: a clear port sets, a set port clears.
    step(5);
    itf.above_high = 4'b1000;
    itf.below_low  = 4'b1000;
    t0 = cyc + 2;
    expect_pulse(t0, 16'hFFFF);
    step(1);
    itf.above_high = '0;
    itf.below_low  = '0;
    chk("t6_set", 32'(itf.port_paused), 32'h8);
    step(2);
    itf.above_high = 4'b1000;
    itf.below_low  = 4'b1000;
    expect_pulse(t0 + GAP, 16'h0000);
    step(1);
    itf.above_high = '0;
    itf.below_low  = '0;
    chk("t6_clear", 32'(itf.port_paused), 32'h0);
    step(25);

    chk("pending_pulses", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
